// File: rtl/mem_pkg.sv
// mem_pkg: access kinds, responder states, funct3 encodings and byte-lane helper for the data-memory path
package mem_pkg;
    typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} mem_size_t;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    function automatic logic [3:0] byte_en(mem_size_t size, logic [1:0] off);
        return (size == SB) ? 4'b0001 << off :
               (size == SH) ? 4'b0011 << {off[1], 1'b0} :
               (size == SW) ? 4'b1111 : 4'b0000;
    endfunction
endpackage

// File: rtl/byte_ram.sv
// byte_ram: single-port RAM with per-byte write enables and registered read
module byte_ram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (we_i && be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    rdata_o <= mem[addr_i];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with wait states, lane steering and fault detection
module dmem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    dmem_state_t state, state_n;
    mem_size_t   size;
    logic [3:0]  cnt, cnt_n, be;
    logic        write_q, accept, legal, misaligned, in_range, fault, ram_we;
    logic [31:0] addr_q, wdata_q, offset, ram_q, store_data, load_data;
    logic [2:0]  funct3_q;
    logic [15:0] lane;
    assign req_ready_o = state == IDLE && !reset_i;
    assign accept      = req_valid_i && req_ready_o;
    always_comb begin
        size  = LW;
        legal = 1'b1;
        case ({write_q, funct3_q})
            {1'b0, F3_B}:  size = LB;
            {1'b0, F3_H}:  size = LH;
            {1'b0, F3_W}:  size = LW;
            {1'b0, F3_BU}: size = LBU;
            {1'b0, F3_HU}: size = LHU;
            {1'b1, F3_B}:  size = SB;
            {1'b1, F3_H}:  size = SH;
            {1'b1, F3_W}:  size = SW;
            default:       legal = 1'b0;
        endcase
    end
    assign offset     = addr_q - BASE_ADDR;
    assign in_range   = addr_q >= BASE_ADDR && {1'b0, offset} < SPAN;
    assign misaligned = ((size == LH || size == LHU || size == SH) && addr_q[0]) ||
                        ((size == LW || size == SW) && addr_q[1:0] != 2'b00);
    assign fault      = !legal || misaligned || !in_range;
    assign be         = byte_en(size, addr_q[1:0]);
    assign store_data = size == SB ? {4{wdata_q[7:0]}} : size == SH ? {2{wdata_q[15:0]}} : wdata_q;
    // reset on the commit edge must still suppress the write
    assign ram_we     = state == ACCESS && write_q && !fault && !reset_i;
    assign lane       = 16'(ram_q >> {addr_q[1:0], 3'b000});
    assign load_data  = size == LB  ? {{24{lane[7]}}, lane[7:0]} :
                        size == LBU ? {24'b0, lane[7:0]} :
                        size == LH  ? {{16{lane[15]}}, lane} :
                        size == LHU ? {16'b0, lane} : ram_q;
    assign rsp_valid_o = state == RESP;
    assign rsp_error_o = rsp_valid_o && fault;
    assign rsp_rdata_o = (rsp_valid_o && !fault && !write_q) ? load_data : 32'b0;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (accept) begin
                if (WAIT_CYCLES > 0) state_n = WAIT;
                else state_n = ACCESS;
                cnt_n = CNT_INIT;
            end
            WAIT: begin
                cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                if (cnt == 4'd0) state_n = ACCESS;
            end
            ACCESS:  state_n = RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
        if (accept) begin
            write_q  <= req_write_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            funct3_q <= req_funct3_i;
        end
    end
    byte_ram #(.DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .be_i    (be),
        .addr_i  (offset[AW+1:2]),
        .wdata_i (store_data),
        .rdata_o (ram_q)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors, latency/throughput, reset-abort and random stream for two responder configs
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic [1:0]       rst, vld, wr;
    logic [1:0][31:0] ad, wd;
    logic [1:0][2:0]  f3;
    wire  [1:0]       rdy, rv, re;
    wire  [1:0][31:0] rd;
    int total = 0, bad = 0;
    logic [31:0] model_mem [64];
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic [31:0] er;
        logic        ee;
    } vec_t;
    vec_t tbl[$];
    logic [31:0] r, mr;
    logic        e, me;
    int          lat;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .reset_i(rst[0]), .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
        .req_write_i(wr[0]), .req_addr_i(ad[0]), .req_wdata_i(wd[0]), .req_funct3_i(f3[0]),
        .rsp_valid_o(rv[0]), .rsp_rdata_o(rd[0]), .rsp_error_o(re[0]));
    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h100), .WAIT_CYCLES(3)) dut1 (
        .clk_i(clk), .reset_i(rst[1]), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
        .req_write_i(wr[1]), .req_addr_i(ad[1]), .req_wdata_i(wd[1]), .req_funct3_i(f3[1]),
        .rsp_valid_o(rv[1]), .rsp_rdata_o(rd[1]), .rsp_error_o(re[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [31:0] a, d, input logic [2:0] f, input logic [31:0] er, input logic ee);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.f = f; v.er = er; v.ee = ee;
        tbl.push_back(v);
    endtask

    // reference memory for dut0 (base 0, 64 words)
    task automatic model(input logic w, input logic [31:0] a, d, input logic [2:0] f, output logic [31:0] rr, output logic ee);
        int idx, sh;
        logic [31:0] word;
        idx = int'(a[7:2]);
        sh = 8 * int'(a[1:0]);
        word = model_mem[idx];
        rr = 32'h0;
        ee = a >= 32'h100;
        case (f)
            3'b000:  ;
            3'b001:  ee |= a[0];
            3'b010:  ee |= a[1:0] != 2'b00;
            3'b100:  ee |= w;
            3'b101:  ee |= w | a[0];
            default: ee = 1'b1;
        endcase
        if (!ee && w) begin
            case (f)
                3'b000:  word[sh +: 8] = d[7:0];
                3'b001:  word[sh +: 16] = d[15:0];
                default: word = d;
            endcase
            model_mem[idx] = word;
        end else if (!ee) begin
            case (f)
                3'b000:  rr = {{24{word[sh+7]}}, word[sh +: 8]};
                3'b001:  rr = {{16{word[sh+15]}}, word[sh +: 16]};
                3'b100:  rr = {24'h0, word[sh +: 8]};
                3'b101:  rr = {16'h0, word[sh +: 16]};
                default: rr = word;
            endcase
        end
    endtask

    task automatic req(input int k, input logic w, input logic [31:0] a, d, input logic [2:0] f,
                       output logic [31:0] rr, output logic ee, output int lt);
        int n;
        @(negedge clk);
        vld[k] = 1'b1; wr[k] = w; ad[k] = a; wd[k] = d; f3[k] = f;
        n = 0;
        while (!rdy[k] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("req ready timeout", 32'(rdy[k]), 32'h1);
        @(posedge clk);
        #1 vld[k] = 1'b0;
        lt = 0;
        do begin @(negedge clk); lt++; end while (!rv[k] && lt < 40);
        if (!rv[k]) chk("req response timeout", 32'(rv[k]), 32'h1);
        rr = rd[k];
        ee = re[k];
        @(negedge clk);
        chk("rsp single pulse", {rv[k], re[k], rd[k][29:0]}, 32'h0);
    endtask

    task automatic hold(input int k, input logic [31:0] a, input int w, input logic [31:0] exp);
        int n, n_rsp, n_rdy;
        logic [31:0] r1;
        r1 = 32'h0;
        @(negedge clk);
        vld[k] = 1'b1; wr[k] = 1'b0; ad[k] = a; wd[k] = 32'h0; f3[k] = 3'b010;
        n = 0;
        while (!rdy[k] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        n = 0; n_rsp = 0; n_rdy = 0;
        while (n_rdy == 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (rv[k] && n_rsp == 0) begin n_rsp = n; r1 = rd[k]; end
            if (rdy[k]) n_rdy = n;
        end
        chk("hold rsp latency", 32'(n_rsp), 32'(w + 2));
        chk("hold rdata", r1, exp);
        chk("hold reaccept gap", 32'(n_rdy), 32'(w + 3));
        @(posedge clk);
        #1 vld[k] = 1'b0;
        @(negedge clk);
        chk("hold ready low after reaccept", 32'(rdy[k]), 32'h0);
        n = 1;
        while (!rv[k] && n < 50) begin @(negedge clk); n++; end
        chk("hold second latency", 32'(n), 32'(w + 2));
        chk("hold second rdata", rd[k], exp);
    endtask

    // store accepted, then reset `skip` negedges later; it must neither respond nor commit
    task automatic abort(input int k, input logic [31:0] a, d, input int skip);
        int n, seen;
        @(negedge clk);
        vld[k] = 1'b1; wr[k] = 1'b1; ad[k] = a; wd[k] = d; f3[k] = 3'b010;
        n = 0;
        while (!rdy[k] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 vld[k] = 1'b0;
        repeat (skip) @(negedge clk);
        rst[k] = 1'b1;
        @(posedge clk);
        #1 rst[k] = 1'b0;
        seen = 0;
        repeat (10) begin @(negedge clk); if (rv[k]) seen++; end
        chk("abort no response", 32'(seen), 32'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 2'b11; vld = 2'b00; wr = 2'b00; ad = '0; wd = '0; f3 = '0;
        add(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        0);
        add(0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 0);
        add(1, 32'h13, 32'h00000080, 3'b000, 32'h0,        0);
        add(0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 0);
        add(0, 32'h13, 32'h0,        3'b100, 32'h00000080, 0);
        add(0, 32'h12, 32'h0,        3'b001, 32'hFFFF80AD, 0);
        add(0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 0);
        add(0, 32'h10, 32'h0,        3'b101, 32'h0000BEEF, 0);
        add(0, 32'h10, 32'h0,        3'b001, 32'hFFFFBEEF, 0);
        add(0, 32'h11, 32'h0,        3'b000, 32'hFFFFFFBE, 0);
        add(0, 32'h12, 32'h0,        3'b100, 32'h000000AD, 0);
        add(1, 32'h16, 32'hFFFF1234, 3'b001, 32'h0,        0);
        add(0, 32'h14, 32'h0,        3'b010, 32'h12340005, 0);
        add(0, 32'h14, 32'h0,        3'b000, 32'h00000005, 0);
        add(0, 32'h17, 32'h0,        3'b000, 32'h00000012, 0);
        add(0, 32'h16, 32'h0,        3'b101, 32'h00001234, 0);
        add(1, 32'h15, 32'h000000F0, 3'b000, 32'h0,        0);
        add(0, 32'h15, 32'h0,        3'b000, 32'hFFFFFFF0, 0);
        add(0, 32'h14, 32'h0,        3'b010, 32'h1234F005, 0);
        add(1, 32'hFC, 32'h5555AAAA, 3'b010, 32'h0,        0);
        add(0, 32'hFC, 32'h0,        3'b010, 32'h5555AAAA, 0);
        add(0, 32'h11, 32'h0,        3'b010, 32'h0,        1);
        add(0, 32'h12, 32'h0,        3'b010, 32'h0,        1);
        add(0, 32'h13, 32'h0,        3'b001, 32'h0,        1);
        add(1, 32'h05, 32'hFFFFFFFF, 3'b001, 32'h0,        1);
        add(0, 32'h04, 32'h0,        3'b011, 32'h0,        1);
        add(0, 32'h04, 32'h0,        3'b110, 32'h0,        1);
        add(0, 32'h04, 32'h0,        3'b111, 32'h0,        1);
        add(1, 32'h04, 32'hFFFFFFFF, 3'b011, 32'h0,        1);
        add(1, 32'h04, 32'hFFFFFFFF, 3'b100, 32'h0,        1);
        add(1, 32'h04, 32'hFFFFFFFF, 3'b101, 32'h0,        1);
        add(0, 32'h100, 32'h0,       3'b010, 32'h0,        1);
        add(1, 32'h100, 32'hFF,      3'b000, 32'h0,        1);
        add(0, 32'hFFFFFFFC, 32'h0,  3'b010, 32'h0,        1);
        add(0, 32'h04, 32'h0,        3'b010, 32'hC0DE0001, 0);
        add(0, 32'h06, 32'h0,        3'b101, 32'h0000C0DE, 0);
        add(0, 32'h08, 32'h0,        3'b010, 32'hC0DE0002, 0);
        repeat (3) @(negedge clk);
        chk("reset outputs", {28'h0, rdy, rv}, 32'h0);
        chk("reset rsp data", {rd[0][30:0], re[0]} | {rd[1][30:0], re[1]}, 32'h0);
        rst = 2'b00;
        @(negedge clk);
        chk("ready after reset", 32'(rdy), 32'h3);
        for (int i = 0; i < 16; i++) begin
            req(0, 1'b1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 3'b010, r, e, lat);
            model(1'b1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 3'b010, mr, me);
            chk("prewrite error", 32'(e), 32'h0);
        end
        foreach (tbl[i]) begin
            req(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, r, e, lat);
            model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].f, mr, me);
            chk($sformatf("vec%0d rdata", i), r, tbl[i].er);
            chk($sformatf("vec%0d error", i), 32'(e), 32'(tbl[i].ee));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'h2);
        end
        hold(0, 32'h10, 0, 32'h80ADBEEF);
        abort(0, 32'h20, 32'h99999999, 0);
        req(0, 1'b0, 32'h20, 32'h0, 3'b010, r, e, lat);
        chk("abort in access keeps word", r, 32'hC0DE0008);
        req(1, 1'b1, 32'h120, 32'hAAAAAAAA, 3'b010, r, e, lat);
        chk("w3 store latency", 32'(lat), 32'h5);
        chk("w3 store rdata", r, 32'h0);
        req(1, 1'b0, 32'h120, 32'h0, 3'b010, r, e, lat);
        chk("w3 load rdata", r, 32'hAAAAAAAA);
        chk("w3 load latency", 32'(lat), 32'h5);
        hold(1, 32'h120, 3, 32'hAAAAAAAA);
        abort(1, 32'h120, 32'h12345678, 2);
        req(1, 1'b0, 32'h120, 32'h0, 3'b010, r, e, lat);
        chk("abort in wait keeps word", r, 32'hAAAAAAAA);
        req(1, 1'b0, 32'h122, 32'h0, 3'b000, r, e, lat);
        chk("w3 lb with base", r, 32'hFFFFFFAA);
        req(1, 1'b0, 32'hFC, 32'h0, 3'b010, r, e, lat);
        chk("below base error", {r[30:0], e}, 32'h1);
        req(1, 1'b0, 32'h1100, 32'h0, 3'b010, r, e, lat);
        chk("past end error", {r[30:0], e}, 32'h1);
        req(1, 1'b0, 32'h10FC, 32'h0, 3'b010, r, e, lat);
        chk("last word no error", 32'(e), 32'h0);
        for (int i = 0; i < 1000; i++) begin
            logic w;
            logic [2:0] f;
            logic [31:0] a, d;
            int sel, ln;
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 19));
            ln = int'($urandom_range(0, 3));
            a = sel < 16 ? 32'(4 * sel + ln) : sel < 18 ? 32'h100 + 32'(ln) : 32'hFFFFFF00 + 32'(ln);
            d = $urandom;
            req(0, w, a, d, f, r, e, lat);
            model(w, a, d, f, mr, me);
            chk($sformatf("rand%0d rdata a=%h f=%0d w=%0d", i, a, f, w), r, mr);
            chk($sformatf("rand%0d error", i), 32'(e), 32'(me));
            chk($sformatf("rand%0d latency", i), 32'(lat), 32'h2);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
